pt_check: RTL

PT_CHECK -- requirements
Module: pt_check

---
 rtl/pt_check.sv | 94 +++++++++
 1 files changed

// File: rtl/pt_check.sv
// pt_check: scans a length-prefixed plaintext message for legal characters; PT_CHECK_STRICT_EN limits the legal set to space and a-z
module pt_check (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic       valid,
  output logic [7:0] bad_addr
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LEN_WAIT = 3'd1;
  localparam logic [2:0] LEN_CAPT = 3'd2;
  localparam logic [2:0] CH_WAIT  = 3'd3;
  localparam logic [2:0] CH_CHECK = 3'd4;
  logic [2:0] state_q, state_d;
  logic       rdy_q, rdy_d, valid_q, valid_d, ch_ok;
  logic [7:0] pt_addr_q, pt_addr_d, bad_addr_q, bad_addr_d, len_q, len_d;
`ifdef PT_CHECK_STRICT_EN
  assign ch_ok = pt_rddata == 8'h20 || (pt_rddata >= 8'h61 && pt_rddata <= 8'h7a);
`else
  assign ch_ok = pt_rddata >= 8'h20 && pt_rddata <= 8'h7e;
`endif
  always_comb begin
    state_d    = state_q;
    rdy_d      = rdy_q;
    valid_d    = valid_q;
    pt_addr_d  = pt_addr_q;
    bad_addr_d = bad_addr_q;
    len_d      = len_q;
    case (state_q)
      IDLE: if (en) begin
        state_d    = LEN_WAIT;
        pt_addr_d  = 8'd0;
        valid_d    = 1'b0;
        bad_addr_d = 8'd0;
        rdy_d      = 1'b0;
      end
      LEN_WAIT: state_d = LEN_CAPT;
      LEN_CAPT: begin
        len_d = pt_rddata;
        if (pt_rddata == 8'd0) begin
          valid_d = 1'b1;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else begin
          pt_addr_d = 8'd1;
          state_d   = CH_WAIT;
        end
      end
      CH_WAIT: state_d = CH_CHECK;
      CH_CHECK: begin
        if (!ch_ok) begin
          bad_addr_d = pt_addr_q;
          rdy_d      = 1'b1;
          state_d    = IDLE;
        end else if (pt_addr_q == len_q) begin
          valid_d = 1'b1;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else begin
          pt_addr_d = pt_addr_q + 8'd1;
          state_d   = CH_WAIT;
        end
      end
      default: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b1;
      valid_q    <= 1'b0;
      pt_addr_q  <= 8'd0;
      bad_addr_q <= 8'd0;
      len_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      valid_q    <= valid_d;
      pt_addr_q  <= pt_addr_d;
      bad_addr_q <= bad_addr_d;
      len_q      <= len_d;
    end
  end
  assign rdy      = rdy_q;
  assign pt_addr  = pt_addr_q;
  assign valid    = valid_q;
  assign bad_addr = bad_addr_q;
endmodule
